// File: rtl/mips_program_loader.sv
// rtl/mips_program_loader.sv - boot loader: byte stream to MIPS instruction memory with XOR check
module mips_program_loader #(
    parameter int Data_Width = 32,
    parameter int Addr_Width = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  rx_ready,
    output logic                  im_we,
    output logic [Addr_Width-1:0] im_waddr,
    output logic [Data_Width-1:0] im_wdata,
    output logic                  core_hold,
    output logic                  done,
    output logic                  error
);

    localparam int Depth = 2 ** Addr_Width;

    typedef enum logic [2:0] {
        BOOT, HDR_HI, HDR_LO, WORD, WRITE, CHK, RUN, ERROR
    } state_t;

    state_t                state;
    logic [7:0]            count_hi;
    logic [15:0]           count;
    logic [Addr_Width-1:0] word_idx;
    logic [1:0]            byte_idx;
    logic [7:0]            xor_acc;
    logic [Data_Width-1:0] shift;

    logic                  accept;
    logic [16:0]           n_hdr;
    logic                  last_word;
    logic [7:0]            xor_next;

    assign accept    = rx_valid && rx_ready;
    assign n_hdr     = {1'b0, count_hi, rx_data};
    assign last_word = (32'(word_idx) == (32'(count) - 32'd1));
    assign xor_next  = xor_acc ^ rx_data;

    // Every output is a decode of registered state so the stream inputs never reach an output combinationally.
    assign rx_ready  = (state == HDR_HI) || (state == HDR_LO) || (state == WORD) || (state == CHK);
    assign im_we     = (state == WRITE);
    assign im_waddr  = word_idx;
    assign im_wdata  = shift;
    assign done      = (state == RUN);
    assign error     = (state == ERROR);
    assign core_hold = (state != RUN);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= BOOT;
            count_hi <= '0;
            count    <= '0;
            word_idx <= '0;
            byte_idx <= '0;
            xor_acc  <= '0;
            shift    <= '0;
        end else begin
            case (state)
                BOOT: begin
                    xor_acc  <= '0;
                    word_idx <= '0;
                    byte_idx <= '0;
                    state    <= HDR_HI;
                end
                HDR_HI: begin
                    if (accept) begin
                        count_hi <= rx_data;
                        xor_acc  <= xor_next;
                        state    <= HDR_LO;
                    end
                end
                HDR_LO: begin
                    if (accept) begin
                        count    <= {count_hi, rx_data};
                        xor_acc  <= xor_next;
                        word_idx <= '0;
                        byte_idx <= '0;
                        if (n_hdr > 17'(Depth))
                            state <= ERROR;
                        else if (n_hdr == 17'd0)
                            state <= CHK;
                        else
                            state <= WORD;
                    end
                end
                WORD: begin
                    if (accept) begin
                        // Big-endian: the first byte of a word ends up in the top byte lane.
                        shift    <= {shift[Data_Width-9:0], rx_data};
                        xor_acc  <= xor_next;
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3)
                            state <= WRITE;
                    end
                end
                WRITE: begin
                    if (last_word) begin
                        state <= CHK;
                    end else begin
                        word_idx <= word_idx + 1'b1;
                        state    <= WORD;
                    end
                end
                CHK: begin
                    if (accept) begin
                        xor_acc <= xor_next;
                        state   <= (xor_next == 8'h00) ? RUN : ERROR;
                    end
                end
                default: state <= state;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_program_loader.sv
// tb/tb_mips_program_loader.sv - scoreboard bench for mips_program_loader
module tb_mips_program_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_ready;
    logic        im_we;
    logic [9:0]  im_waddr;
    logic [31:0] im_wdata;
    logic        core_hold;
    logic        done;
    logic        error;

    int n_cmp = 0;
    int n_bad = 0;
    int writes_seen = 0;

    logic [31:0] img[$];
    logic [63:0] sb[$];

    mips_program_loader #(.Data_Width(32), .Addr_Width(10)) dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(rx_ready), .im_we(im_we), .im_waddr(im_waddr), .im_wdata(im_wdata),
        .core_hold(core_hold), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst && im_we) begin
            logic [63:0] e;
            writes_seen++;
            check("we_rdy_low", 32'(rx_ready), 32'd0);
            if (sb.size() == 0) begin
                check("spurious_we", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("waddr", 32'(im_waddr), e[63:32]);
                check("wdata", im_wdata, e[31:0]);
            end
        end
    end

    // Called at a negedge; returns at the negedge after the edge that accepted the byte.
    task automatic send(input logic [7:0] b, input int maxgap);
        int gap, cnt;
        gap = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
        repeat (gap) begin
            rx_valid = 1'b0;
            @(negedge clk);
        end
        rx_valid = 1'b1;
        rx_data  = b;
        cnt = 0;
        while (!rx_ready && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        if (cnt >= 50) begin
            check("rdy_timeout", 32'd0, 32'd1);
        end else begin
            @(negedge clk);
        end
    endtask

    task automatic load(input logic [7:0] cks_flip, input int maxgap);
        logic [7:0]  x;
        logic [15:0] n;
        logic [31:0] w;
        n = 16'(img.size());
        x = n[15:8] ^ n[7:0];
        send(n[15:8], maxgap);
        send(n[7:0], maxgap);
        for (int i = 0; i < img.size(); i++) begin
            w = img[i];
            sb.push_back({32'(i), w});
            for (int b = 3; b >= 0; b--) begin
                x = x ^ w[8*b +: 8];
                send(w[8*b +: 8], maxgap);
            end
        end
        send(x ^ cks_flip, maxgap);
        rx_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        rx_valid = 1'b0;
        #1;
        check("rst_we", 32'(im_we), 32'd0);
        check("rst_hold", 32'(core_hold), 32'd1);
        check("rst_ready", 32'(rx_ready), 32'd0);
        repeat (2) @(negedge clk);
        sb.delete();
        rst = 1'b1;
    endtask

    task automatic set_test1();
        img.delete();
        img.push_back(32'h20080005);
        img.push_back(32'h2009000A);
    endtask

    initial begin
        int ws;
        #3;
        rst = 1'b0;
        @(negedge clk);
        check("rst_waddr", 32'(im_waddr), 32'd0);
        check("rst_wdata", im_wdata, 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_hold0", 32'(core_hold), 32'd1);
        check("rst_ready0", 32'(rx_ready), 32'd0);
        check("rst_we0", 32'(im_we), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Two-word image, stream 00 02 20 08 00 05 20 09 00 0A 0C
        set_test1();
        ws = writes_seen;
        load(8'h00, 0);
        check("t1_done", 32'(done), 32'd1);
        check("t1_hold", 32'(core_hold), 32'd0);
        check("t1_error", 32'(error), 32'd0);
        check("t1_writes", 32'(writes_seen - ws), 32'd2);
        check("t1_sb_empty", 32'(sb.size()), 32'd0);
        rx_valid = 1'b1;
        @(negedge clk);
        check("t1_run_ready", 32'(rx_ready), 32'd0);
        rx_valid = 1'b0;

        // Bad checksum 0x0D
        do_reset();
        ws = writes_seen;
        load(8'h01, 0);
        check("t2_writes", 32'(writes_seen - ws), 32'd2);
        check("t2_error", 32'(error), 32'd1);
        check("t2_done", 32'(done), 32'd0);
        check("t2_hold", 32'(core_hold), 32'd1);
        check("t2_ready", 32'(rx_ready), 32'd0);

        // Empty image 00 00 00
        do_reset();
        img.delete();
        ws = writes_seen;
        send(8'h00, 0);
        send(8'h00, 0);
        check("t3_done_early", 32'(done), 32'd0);
        send(8'h00, 0);
        rx_valid = 1'b0;
        check("t3_done", 32'(done), 32'd1);
        check("t3_hold", 32'(core_hold), 32'd0);
        check("t3_writes", 32'(writes_seen - ws), 32'd0);

        // Oversize header 04 01
        do_reset();
        ws = writes_seen;
        send(8'h04, 0);
        send(8'h01, 0);
        check("t4_error", 32'(error), 32'd1);
        rx_valid = 1'b1;
        rx_data  = 8'h20;
        repeat (4) @(negedge clk);
        check("t4_ready", 32'(rx_ready), 32'd0);
        check("t4_writes", 32'(writes_seen - ws), 32'd0);
        rx_valid = 1'b0;

        // Random gaps in rx_valid
        do_reset();
        set_test1();
        ws = writes_seen;
        load(8'h00, 3);
        check("t5_done", 32'(done), 32'd1);
        check("t5_writes", 32'(writes_seen - ws), 32'd2);
        check("t5_sb_empty", 32'(sb.size()), 32'd0);

        // Reset after 2 of 4 bytes of word 1, then full reload
        do_reset();
        set_test1();
        sb.push_back({32'd0, 32'h20080005});
        send(8'h00, 0); send(8'h02, 0);
        send(8'h20, 0); send(8'h08, 0); send(8'h00, 0); send(8'h05, 0);
        send(8'h20, 0); send(8'h09, 0);
        check("t6_sb_w0", 32'(sb.size()), 32'd0);
        do_reset();
        ws = writes_seen;
        load(8'h00, 0);
        check("t6_done", 32'(done), 32'd1);
        check("t6_writes", 32'(writes_seen - ws), 32'd2);

        // Reset during a WRITE cycle
        do_reset();
        sb.push_back({32'd0, 32'h20080005});
        send(8'h00, 0); send(8'h02, 0);
        send(8'h20, 0); send(8'h08, 0); send(8'h00, 0); send(8'h05, 0);
        check("t7_we_before", 32'(im_we), 32'd1);
        do_reset();
        ws = writes_seen;
        load(8'h00, 0);
        check("t7_done", 32'(done), 32'd1);
        check("t7_writes", 32'(writes_seen - ws), 32'd2);

        // Full-depth image: N = 1024, last write at address 1023
        do_reset();
        img.delete();
        for (int i = 0; i < 1024; i++) img.push_back($urandom);
        ws = writes_seen;
        load(8'h00, 0);
        check("t8_done", 32'(done), 32'd1);
        check("t8_writes", 32'(writes_seen - ws), 32'd1024);
        check("t8_sb_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
